// File: rtl/dcache_2way.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU and full-cache flush.
// Hits complete combinationally with zero stall; misses and flushes hold busywait until memory transfers finish.
module dcache_2way #(
    parameter int ADDR_W      = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int SETS        = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [ADDR_W-1:0]                      address,
    input  logic [7:0]                             cpu_writeData,
    input  logic                                   read,
    input  logic                                   write,
    input  logic                                   flush,
    output logic [7:0]                             cpu_readData,
    output logic                                   busywait,
    output logic                                   flush_done,
    output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]  mem_address,
    output logic [8*BLOCK_BYTES-1:0]               mem_writedata,
    input  logic [8*BLOCK_BYTES-1:0]               mem_readdata,
    output logic                                   mem_read,
    output logic                                   mem_write,
    input  logic                                   mem_busywait
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = 8 * BLOCK_BYTES;
    localparam int PTR_W = IDX_W + 2;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(2 * SETS);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITEBACK  = 3'd1,
        FETCH      = 3'd2,
        FLUSH_SCAN = 3'd3,
        FLUSH_WB   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic [1:0]        valid_q [SETS];
    logic [1:0]        dirty_q [SETS];
    logic              lru_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][2];
    logic [BLK_W-1:0]  data_q  [SETS][2];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [1:0]        way_hit;
    logic              hit, hit_way, victim, victim_dirty;
    logic              req, idle, acc_hit, fill;
    logic [IDX_W-1:0]  ptr_set;
    logic              ptr_way;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_idx = address[OFF_W +: IDX_W];
    assign req_off = address[OFF_W-1:0];

    assign way_hit[0] = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
    assign way_hit[1] = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
    assign hit        = |way_hit;
    assign hit_way    = way_hit[1];

    // Prefer an empty way; only fall back to LRU when both ways hold data.
    assign victim       = !valid_q[req_idx][0] ? 1'b0 :
                          !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];
    assign victim_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];

    assign req     = read | write;
    assign idle    = (state_q == IDLE);
    assign acc_hit = idle && req && hit;
    assign fill    = (state_q == FETCH) && !mem_busywait;
    assign ptr_set = ptr_q[IDX_W:1];
    assign ptr_way = ptr_q[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (acc_hit) begin
                lru_q[req_idx] <= ~hit_way;
                if (write) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (state_q == WRITEBACK && !mem_busywait) dirty_q[req_idx][victim] <= 1'b0;
            if (fill) begin
                valid_q[req_idx][victim] <= 1'b1;
                dirty_q[req_idx][victim] <= 1'b0;
                lru_q[req_idx]           <= ~victim;
            end
            if (state_q == FLUSH_WB && !mem_busywait) dirty_q[ptr_set][ptr_way] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clock) begin
        if (acc_hit && write) data_q[req_idx][hit_way][{req_off, 3'b000} +: 8] <= cpu_writeData;
        if (fill) begin
            tag_q[req_idx][victim]  <= req_tag;
            data_q[req_idx][victim] <= mem_readdata;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = victim_dirty ? WRITEBACK : FETCH;
                end else if (flush && !req) begin
                    state_d = FLUSH_SCAN;
                    ptr_d   = '0;
                end
            end
            WRITEBACK: if (!mem_busywait) state_d = FETCH;
            FETCH:     if (!mem_busywait) state_d = IDLE;
            FLUSH_SCAN: begin
                if (ptr_q == PTR_END)
                    state_d = IDLE;
                else if (valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way])
                    state_d = FLUSH_WB;
                else
                    ptr_d = ptr_q + 1'b1;
            end
            FLUSH_WB: begin
                if (!mem_busywait) begin
                    state_d = FLUSH_SCAN;
                    ptr_d   = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        flush_done    = 1'b0;
        unique case (state_q)
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[req_idx][victim], req_idx};
                mem_writedata = data_q[req_idx][victim];
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {req_tag, req_idx};
            end
            FLUSH_SCAN: flush_done = (ptr_q == PTR_END);
            FLUSH_WB: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[ptr_set][ptr_way], ptr_set};
                mem_writedata = data_q[ptr_set][ptr_way];
            end
            default: ;
        endcase
    end

    // Gated by reset so an aborted miss releases the CPU immediately.
    assign busywait     = !reset && ((req && !(idle && hit)) || !idle);
    assign cpu_readData = (idle && read && hit) ? data_q[req_idx][hit_way][{req_off, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_dcache_2way.sv
// Directed plus random stimulus for dcache_2way, checked against a line-level cache model and a flat memory image.
module tb_dcache_2way;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  address, cpu_writeData, cpu_readData;
    logic        read, write, flush, busywait, flush_done;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_read, mem_write;
    logic        mem_busywait = 1'b0;

    dcache_2way #(.ADDR_W(8), .BLOCK_BYTES(4), .SETS(4)) dut (
        .clock(clock), .reset(reset), .address(address), .cpu_writeData(cpu_writeData),
        .read(read), .write(write), .flush(flush), .cpu_readData(cpu_readData),
        .busywait(busywait), .flush_done(flush_done), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_arr [256];
    logic [7:0]  shadow  [256];
    int          mem_lat = 0;

    bit          mv [4][2];
    bit          md [4][2];
    int          mt [4][2];
    bit          mlru [4];

    bit          log_wr  [$];
    int          log_blk [$];
    logic [31:0] log_dat [$];

    // Behavioural memory: mem_lat busy cycles, then completes; every completed transfer is logged.
    bit active = 1'b0;
    int remaining = 0;
    int b;
    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            b = int'(mem_address);
            if (!active) begin
                active = 1'b1;
                remaining = mem_lat;
            end else if (remaining > 0) begin
                remaining--;
            end
            mem_busywait = (remaining > 0);
            mem_readdata = {mem_arr[b*4+3], mem_arr[b*4+2], mem_arr[b*4+1], mem_arr[b*4]};
            if (!mem_busywait) begin
                if (mem_write)
                    for (int k = 0; k < 4; k++) mem_arr[b*4+k] = mem_writedata[8*k +: 8];
                log_wr.push_back(mem_write);
                log_blk.push_back(b);
                log_dat.push_back(mem_write ? mem_writedata : 32'h0);
                active = 1'b0;
            end
        end else begin
            active = 1'b0;
            mem_busywait = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            mlru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                mt[s][w] = 0;
            end
        end
    endtask

    function automatic logic [31:0] shadow_blk(input int blk);
        return {shadow[blk*4+3], shadow[blk*4+2], shadow[blk*4+1], shadow[blk*4]};
    endfunction

    task automatic clear_log();
        log_wr.delete();
        log_blk.delete();
        log_dat.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic do_access(input bit wr, input logic [7:0] a, input logic [7:0] wd);
        int idx, tg, hw, vic, exp_stall, stall, wb_blk, exp_txn;
        logic [7:0]  exp_rd, got_rd;
        logic [31:0] wb_dat;
        idx = int'(a[3:2]);
        tg  = int'(a[7:4]);
        hw  = -1;
        wb_blk = -1;
        wb_dat = 32'h0;
        exp_stall = 0;
        exp_txn = 0;
        for (int w = 0; w < 2; w++)
            if (mv[idx][w] && mt[idx][w] == tg) hw = w;
        if (hw < 0) begin
            vic = !mv[idx][0] ? 0 : (!mv[idx][1] ? 1 : int'(mlru[idx]));
            if (mv[idx][vic] && md[idx][vic]) begin
                wb_blk = mt[idx][vic] * 4 + idx;
                wb_dat = shadow_blk(wb_blk);
                exp_stall = 2 * mem_lat + 3;
                exp_txn = 2;
            end else begin
                exp_stall = mem_lat + 2;
                exp_txn = 1;
            end
            mv[idx][vic] = 1'b1;
            md[idx][vic] = 1'b0;
            mt[idx][vic] = tg;
            hw = vic;
        end
        mlru[idx] = (hw == 0);
        exp_rd = shadow[a];
        if (wr) begin
            md[idx][hw] = 1'b1;
            shadow[a] = wd;
        end

        clear_log();
        address = a;
        cpu_writeData = wd;
        read = !wr;
        write = wr;
        stall = 0;
        @(negedge clock);
        while (busywait && stall < 300) begin
            stall++;
            @(negedge clock);
        end
        got_rd = cpu_readData;
        @(posedge clock);
        #1;
        read = 1'b0;
        write = 1'b0;

        chk("stall_cycles", stall, exp_stall);
        if (!wr) chk("read_data", got_rd, exp_rd);
        chk("mem_txn_count", log_wr.size(), exp_txn);
        if (exp_txn == 2 && log_wr.size() == 2) begin
            chk("wb_is_write", log_wr[0], 1);
            chk("wb_block", log_blk[0], wb_blk);
            chk("wb_data", log_dat[0], wb_dat);
            chk("fetch_is_read", log_wr[1], 0);
            chk("fetch_block", log_blk[1], a >> 2);
        end else if (exp_txn == 1 && log_wr.size() == 1) begin
            chk("fetch_is_read", log_wr[0], 0);
            chk("fetch_block", log_blk[0], a >> 2);
        end
    endtask

    task automatic do_flush();
        int          exp_blk [$];
        logic [31:0] exp_dat [$];
        int          done_cnt, cyc;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++)
                if (mv[s][w] && md[s][w]) begin
                    exp_blk.push_back(mt[s][w] * 4 + s);
                    exp_dat.push_back(shadow_blk(mt[s][w] * 4 + s));
                    md[s][w] = 1'b0;
                end
        clear_log();
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        done_cnt = 0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) chk("flush_busywait", busywait, 1);
            if (flush_done) done_cnt++;
        end
        repeat (3) begin
            @(negedge clock);
            if (flush_done) done_cnt++;
        end
        chk("flush_done_pulses", done_cnt, 1);
        chk("busy_after_flush", busywait, 0);
        chk("flush_txn_count", log_wr.size(), exp_blk.size());
        for (int i = 0; i < exp_blk.size() && i < log_wr.size(); i++) begin
            chk("flush_is_write", log_wr[i], 1);
            chk("flush_block", log_blk[i], exp_blk[i]);
            chk("flush_data", log_dat[i], exp_dat[i]);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        flush = 1'b0;
        address = 8'h00;
        cpu_writeData = 8'h00;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        mem_arr[0] = 8'hAA;
        mem_arr[1] = 8'hBB;
        mem_arr[2] = 8'hCC;
        mem_arr[3] = 8'hDD;
        for (int i = 0; i < 256; i++) shadow[i] = mem_arr[i];
        model_reset();

        #12;
        chk("rst_busywait", busywait, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_writedata", mem_writedata, 0);
        chk("rst_cpu_readData", cpu_readData, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // First fill after reset, then a same-block hit.
        mem_lat = 3;
        do_access(1'b0, 8'h00, 8'h00);
        do_access(1'b0, 8'h03, 8'h00);

        // Fill both ways of set 0, touch 0x00, then 0x20 evicts the 0x10 line.
        do_access(1'b0, 8'h10, 8'h00);
        do_access(1'b0, 8'h00, 8'h00);
        do_access(1'b0, 8'h20, 8'h00);

        // Dirty byte in block 0 is written back before the 0x41 fetch.
        do_access(1'b1, 8'h01, 8'h55);
        do_access(1'b0, 8'h21, 8'h00);
        do_access(1'b0, 8'h41, 8'h00);
        do_access(1'b0, 8'h01, 8'h00);

        // Dirty lines in sets 1 and 3, then flush and re-read.
        mem_lat = 1;
        do_access(1'b1, 8'h04, 8'h11);
        do_access(1'b1, 8'h0C, 8'h33);
        do_flush();
        do_access(1'b0, 8'h04, 8'h00);
        do_access(1'b0, 8'h0C, 8'h00);

        // Reset asserted while a fetch is stalled by memory.
        mem_lat = 10;
        address = 8'h80;
        read = 1'b1;
        n = 0;
        @(negedge clock);
        while (!mem_read && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("reached_fetch", mem_read, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_mem_read", mem_read, 0);
        chk("abort_mem_write", mem_write, 0);
        chk("abort_busywait", busywait, 0);
        #10;
        read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) shadow[i] = mem_arr[i];
        mem_lat = 2;
        do_access(1'b0, 8'h80, 8'h00);

        // Zero-latency memory: a clean miss stalls exactly two cycles.
        mem_lat = 0;
        do_access(1'b0, 8'hC4, 8'h00);

        for (int i = 0; i < 150; i++) begin
            ra = {2'b00, 2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
            mem_lat = $urandom_range(0, 3);
            do_access(1'($urandom_range(0, 1)), ra, 8'($urandom));
        end
        mem_lat = 1;
        do_flush();
        for (int i = 0; i < 64; i++) do_access(1'b0, 8'(i), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
